// File: rtl/mw_writeback_regfile_pkg.sv
// Shared constants for the writeback stage and register file.
// MEM_WB bundle field positions live here so producers and consumers agree.
package mw_writeback_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int MW_W   = 72;

  localparam int FLUSH   = 71;
  localparam int MEMRD   = 70;
  localparam int WE      = 69;
  localparam int LD_HI   = 68;
  localparam int LD_LO   = 37;
  localparam int ALU_HI  = 36;
  localparam int ALU_LO  = 5;
  localparam int DEST_HI = 4;
  localparam int DEST_LO = 0;

endpackage

// File: rtl/mw_writeback_regfile_if.sv
// MEM_WB input, decode read ports and writeback/debug outputs.
// master drives the bundle and read addresses; slave is the writeback stage.
interface mw_writeback_regfile_if;
  import mw_writeback_regfile_pkg::*;

  logic [MW_W-1:0]   MEM_WB;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] retire_count;

  modport master (
    output MEM_WB, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    input  wb_valid, wb_dest, wb_data,
    input  retire_count
  );

  modport slave (
    input  MEM_WB, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    output wb_valid, wb_dest, wb_data,
    output retire_count
  );

endinterface

// File: rtl/mw_writeback_regfile_2r1w.sv
// 32x32 register file, one write port, two write-first read ports.
// r0 reads as zero; synchronous reset clears every entry.
module mw_writeback_regfile_2r1w
  import mw_writeback_regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr;

  assign w_wr = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle writes are forwarded so decode never sees stale data.
  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    o_rdata_b = r_regs[i_raddr_b];
    if (w_wr && i_raddr_a == i_waddr) o_rdata_a = i_wdata;
    if (w_wr && i_raddr_b == i_waddr) o_rdata_b = i_wdata;
    if (i_raddr_a == '0) o_rdata_a = '0;
    if (i_raddr_b == '0) o_rdata_b = '0;
  end

endmodule

// File: rtl/mw_writeback_regfile.sv
// Writeback stage: picks load or ALU data, commits to the register file,
// and registers the last committed result plus a retired-write counter.
module mw_writeback_regfile
  import mw_writeback_regfile_pkg::*;
(
  input logic clk,
  input logic rst,
  mw_writeback_regfile_if.slave bus
);

  logic              w_flush;
  logic              w_memrd;
  logic              w_we;
  logic [DATA_W-1:0] w_ld;
  logic [DATA_W-1:0] w_alu;
  logic [ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0] w_sel;
  logic              w_commit;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;
  logic [DATA_W-1:0] r_retire_count;

  assign w_flush = bus.MEM_WB[FLUSH];
  assign w_memrd = bus.MEM_WB[MEMRD];
  assign w_we    = bus.MEM_WB[WE];
  assign w_ld    = bus.MEM_WB[LD_HI:LD_LO];
  assign w_alu   = bus.MEM_WB[ALU_HI:ALU_LO];
  assign w_dest  = bus.MEM_WB[DEST_HI:DEST_LO];
  assign w_sel   = w_memrd ? w_ld : w_alu;

  // Gating on rst also disables the read bypass during reset.
  assign w_commit = w_we && !w_flush && (w_dest != '0) && !rst;

  mw_writeback_regfile_2r1w u_rf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (w_commit),
    .i_waddr   (w_dest),
    .i_wdata   (w_sel),
    .i_raddr_a (bus.rd_addr_a),
    .i_raddr_b (bus.rd_addr_b),
    .o_rdata_a (bus.rd_data_a),
    .o_rdata_b (bus.rd_data_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_data      <= '0;
      r_retire_count <= '0;
    end else if (w_commit) begin
      r_wb_valid     <= 1'b1;
      r_wb_dest      <= w_dest;
      r_wb_data      <= w_sel;
      r_retire_count <= r_retire_count + 1'b1;
    end else if (w_flush) begin
      r_wb_valid <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_dest      = r_wb_dest;
  assign bus.wb_data      = r_wb_data;
  assign bus.retire_count = r_retire_count;

endmodule
